key_note_select: RTL

// - Upstream stage of the tone generators: debounces 8 piano keys (ui_in) and selects one note.
// - Emits the half-period count a tone_gen-style divider needs, plus a note_on gate.
// - Sits between the pad inputs and the tone generators in the piano top level.

---
 rtl/key_note_select.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/key_note_select.sv
// Debounces eight piano keys, picks the lowest pressed one and emits its divider half-period.
// Optional `SIMPLEPIANO_OCTAVE_EN adds octave_up (halves the half-period when sampled high on note start).
module key_note_select #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [7:0]           keys_in,
`ifdef SIMPLEPIANO_OCTAVE_EN
    input  logic                 octave_up,
`endif
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 note_on,
    output logic                 note_change,
    output logic [2:0]           key_idx
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef SIMPLEPIANO_OCTAVE_EN
    localparam int SYNC_W = 9;
`else
    localparam int SYNC_W = 8;
`endif

    generate
        if (CNT_WIDTH < 9) begin : g_bad_cnt_width
            $error("key_note_select: CNT_WIDTH must be >= 9 to hold the note table");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("key_note_select: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    logic [SYNC_W-1:0] sync_in;
    logic [SYNC_W-1:0] sync_bits;
    logic [7:0]        keys_s;
    logic              any;
    logic [2:0]        enc;
    logic [CNT_WIDTH-1:0] hp_sel;

    state_t               state_reg;
    logic [DB_W-1:0]      cnt_reg;
    logic [2:0]           cand_reg;
    logic [2:0]           key_idx_reg;
    logic [CNT_WIDTH-1:0] half_period_reg;
    logic                 note_on_reg;
    logic                 note_change_reg;

`ifdef SIMPLEPIANO_OCTAVE_EN
    logic octave_s;
    assign sync_in  = {octave_up, keys_in};
    assign octave_s = sync_bits[8];
`else
    assign sync_in  = keys_in;
`endif
    assign keys_s = sync_bits[7:0];

    // Two-flop synchroniser per input bit; cleared together with the FSM.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (!rst_n || !ena) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sync_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    function automatic logic [8:0] note_hp(input logic [2:0] idx);
        case (idx)
            3'd0:    note_hp = 9'd478;
            3'd1:    note_hp = 9'd426;
            3'd2:    note_hp = 9'd379;
            3'd3:    note_hp = 9'd358;
            3'd4:    note_hp = 9'd319;
            3'd5:    note_hp = 9'd284;
            3'd6:    note_hp = 9'd253;
            default: note_hp = 9'd239;
        endcase
    endfunction

    // Lowest pressed key has priority.
    always_comb begin
        enc = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (keys_s[i]) enc = 3'(i);
        end
        any = |keys_s;
    end

    always_comb begin
        hp_sel = CNT_WIDTH'(note_hp(cand_reg));
`ifdef SIMPLEPIANO_OCTAVE_EN
        if (octave_s) hp_sel = hp_sel >> 1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            cand_reg        <= 3'd0;
            key_idx_reg     <= 3'd0;
            half_period_reg <= '0;
            note_on_reg     <= 1'b0;
            note_change_reg <= 1'b0;
        end else begin
            note_change_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any) begin
                        cand_reg  <= enc;
                        cnt_reg   <= '0;
                        state_reg <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!any || enc != cand_reg) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg       <= HOLD;
                        key_idx_reg     <= cand_reg;
                        half_period_reg <= hp_sel;
                        note_on_reg     <= 1'b1;
                        note_change_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    note_on_reg <= 1'b1;
                    if (!any || enc != key_idx_reg) begin
                        cnt_reg   <= '0;
                        state_reg <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A key that comes back before the count expires is treated as a glitch.
                    if (any && enc == key_idx_reg) begin
                        state_reg <= HOLD;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE;
                        note_on_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign half_period = half_period_reg;
    assign note_on     = note_on_reg;
    assign note_change = note_change_reg;
    assign key_idx     = key_idx_reg;
endmodule
